// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the 16-bit data RAM: one op in flight, held load response.
// Optional address bounds check enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [DATA_WIDTH-1:0] ReqData,
    input  logic [TAG_WIDTH-1:0]  ReqDest,
    output logic [ADDR_WIDTH-1:0] DataAddress,
    output logic                  ReadMem,
    output logic                  WriteMem,
    output logic [DATA_WIDTH-1:0] DataIn,
    input  logic [DATA_WIDTH-1:0] DataOut,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [DATA_WIDTH-1:0] RespData,
    output logic [TAG_WIDTH-1:0]  RespDest,
    output logic [15:0]           LoadCount,
    output logic [15:0]           StoreCount,
    output logic                  AddrErr
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StResp = 2'd3;
    localparam logic [15:0] CntMax = 16'hFFFF;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [TAG_WIDTH-1:0]  dest_q, dest_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [TAG_WIDTH-1:0]  rdest_q, rdest_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [15:0]           load_cnt_q, load_cnt_d;
    logic [15:0]           store_cnt_q, store_cnt_d;
    logic                  accept;
    logic                  op_ok;

    assign accept = ReqValid && ReqReady;

`ifdef MEM_BOUNDS_CHECK_EN
    logic req_in_range;
    logic op_ok_q, op_ok_d;
    logic addr_err_q, addr_err_d;

    assign req_in_range = (32'(ReqAddress) < DEPTH);

    always_comb begin
        op_ok_d    = op_ok_q;
        addr_err_d = addr_err_q;
        if (accept) begin
            op_ok_d = req_in_range;
            if (!req_in_range) addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ok_q    <= 1'b1;
            addr_err_q <= 1'b0;
        end else begin
            op_ok_q    <= op_ok_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign op_ok   = op_ok_q;
    assign AddrErr = addr_err_q;
`else
    assign op_ok   = 1'b1;
    assign AddrErr = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dest_d       = dest_q;
        rdata_d      = rdata_q;
        rdest_d      = rdest_q;
        resp_valid_d = resp_valid_q;
        load_cnt_d   = load_cnt_q;
        store_cnt_d  = store_cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = ReqAddress;
                    wdata_d = ReqData;
                    dest_d  = ReqDest;
                    state_d = ReqWrite ? StWr : StRd;
                end
            end
            StWr: begin
                if (op_ok && store_cnt_q != CntMax) store_cnt_d = store_cnt_q + 16'd1;
                state_d = StIdle;
            end
            StRd: begin
                // Out-of-range loads still complete, returning zero.
                rdata_d      = op_ok ? DataOut : '0;
                rdest_d      = dest_q;
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (RespReady) begin
                    resp_valid_d = 1'b0;
                    if (load_cnt_q != CntMax) load_cnt_d = load_cnt_q + 16'd1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            dest_q       <= '0;
            rdata_q      <= '0;
            rdest_q      <= '0;
            resp_valid_q <= 1'b0;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dest_q       <= dest_d;
            rdata_q      <= rdata_d;
            rdest_q      <= rdest_d;
            resp_valid_q <= resp_valid_d;
            load_cnt_q   <= load_cnt_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign ReqReady    = (state_q == StIdle);
    assign ReadMem     = (state_q == StRd) && op_ok;
    assign WriteMem    = (state_q == StWr) && op_ok;
    assign DataAddress = addr_q;
    assign DataIn      = wdata_q;
    assign RespValid   = resp_valid_q;
    assign RespData    = rdata_q;
    assign RespDest    = rdest_q;
    assign LoadCount   = load_cnt_q;
    assign StoreCount  = store_cnt_q;

endmodule
